// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants and helpers.
//   SBOX  - 256-entry forward S-box, byte 0x00 at index 0
//   RCON  - round constants for rounds 1..10 (index = round-1)
//   aes_state_e - cipher FSM state encoding
//   xtime, sub_byte, sub_word, rot_word, mix_column - round primitives
// No ports (package).
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x in GF(2^8), reducing modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]),
            sub_byte(w[15:8]),  sub_byte(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Column bytes a0..a3 with a0 in the top byte; 3*a = xtime(a) ^ a.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_key_expand.sv
// aes_key_expand: one combinational AES-128 key-schedule step.
//   key_prev_i [127:0] - round key K_{r-1}, word w0 in bits [127:96]
//   round_i    [3:0]   - round index r (1..10) selecting Rcon
//   key_next_o [127:0] - round key K_r
module aes_key_expand
  import aes_pkg::*;
(
  input  logic [127:0] key_prev_i,
  input  logic [3:0]   round_i,
  output logic [127:0] key_next_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [7:0]  rcon;

  assign {w0, w1, w2, w3} = key_prev_i;

  // Out-of-range rounds only occur when the datapath is not running.
  always_comb begin
    rcon = '0;
    if (round_i >= 4'd1 && round_i <= 4'd10) rcon = RCON[round_i - 4'd1];
  end

  assign n0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next_o = {n0, n1, n2, n3};

endmodule

// File: rtl/top.sv
// top: iterative AES-128 encryption core, one round per clock with
// on-the-fly key expansion.
//   clk, reset      - clock, synchronous active-high reset
//   data_valid_in   - plain_text valid
//   plain_text      - plaintext block, byte 0 in bits [127:120]
//   key_valid_in    - cipher_key valid
//   cipher_key      - key, byte 0 in bits [127:120]
//   data_valid_out  - one-cycle pulse with a new cipher_text
//   cipher_text     - ciphertext, held until the next result
// Build option: TOP_KEY_REGISTER_EN adds a stored-key register so a block
// can start on data_valid_in alone using a previously loaded key.
module top
  import aes_pkg::*;
#(
  parameter int KEY_LEN       = 128,
  parameter int DATA_LEN      = 128,
  parameter int NUMS_OF_ROUND = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] plain_text,
  input  logic                key_valid_in,
  input  logic [KEY_LEN-1:0]  cipher_key,
  output logic                data_valid_out,
  output logic [DATA_LEN-1:0] cipher_text
);

  localparam logic [3:0] LAST_ROUND = 4'(NUMS_OF_ROUND);

  aes_state_e          fsm_q;
  logic [3:0]          round_q;
  logic [127:0]        state_q, state_d;
  logic [127:0]        key_q, key_d;
  logic [DATA_LEN-1:0] cipher_text_q;
  logic                data_valid_out_q;
  logic                start;
  logic [127:0]        start_key;

`ifdef TOP_KEY_REGISTER_EN
  logic [127:0] stored_key_q;
  assign start     = data_valid_in;
  assign start_key = key_valid_in ? cipher_key : stored_key_q;
`else
  assign start     = data_valid_in & key_valid_in;
  assign start_key = cipher_key;
`endif

  aes_key_expand u_key_expand (
    .key_prev_i (key_q),
    .round_i    (round_q),
    .key_next_o (key_d)
  );

  // Byte views: index 0 is the most significant byte, so column c is
  // bytes 4c..4c+3 and row r of column c is byte 4c+r.
  logic [0:15][7:0] sb, sr;
  logic [0:3][31:0] mc;

  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int unsigned i = 0; i < 16; i++) sb[i] = sub_byte(state_q[127-8*i -: 8]);
    // ShiftRows: row r rotates left by r columns.
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int unsigned c = 0; c < 4; c++) mc[c] = mix_column(sr[4*c +: 4]);
    state_d = ((round_q == LAST_ROUND) ? 128'(sr) : 128'(mc)) ^ key_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q            <= IDLE;
      round_q          <= '0;
      state_q          <= '0;
      key_q            <= '0;
      cipher_text_q    <= '0;
      data_valid_out_q <= 1'b0;
`ifdef TOP_KEY_REGISTER_EN
      stored_key_q     <= '0;
`endif
    end else begin
      data_valid_out_q <= 1'b0;
      case (fsm_q)
        IDLE, DONE: begin
`ifdef TOP_KEY_REGISTER_EN
          if (key_valid_in) stored_key_q <= cipher_key;
`endif
          if (start) begin
            state_q <= plain_text ^ start_key;
            key_q   <= start_key;
            round_q <= 4'd1;
            fsm_q   <= RUN;
          end else begin
            round_q <= '0;
            fsm_q   <= IDLE;
          end
        end
        RUN: begin
          state_q <= state_d;
          key_q   <= key_d;
          if (round_q == LAST_ROUND) begin
            cipher_text_q    <= state_d;
            data_valid_out_q <= 1'b1;
            round_q          <= '0;
            fsm_q            <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: begin
          round_q <= '0;
          fsm_q   <= IDLE;
        end
      endcase
    end
  end

  assign data_valid_out = data_valid_out_q;
  assign cipher_text    = cipher_text_q;

endmodule

// File: tb/tb_top.sv
module tb_top;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_valid_in;
  logic [127:0] plain_text;
  logic         key_valid_in;
  logic [127:0] cipher_key;
  logic         data_valid_out;
  logic [127:0] cipher_text;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;

  top #(.KEY_LEN(128), .DATA_LEN(128), .NUMS_OF_ROUND(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .data_valid_in  (data_valid_in),
    .plain_text     (plain_text),
    .key_valid_in   (key_valid_in),
    .cipher_key     (cipher_key),
    .data_valid_out (data_valid_out),
    .cipher_text    (cipher_text)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic drive_start(input logic [127:0] pt, input logic [127:0] key);
    plain_text    = pt;
    cipher_key    = key;
    data_valid_in = 1'b1;
    key_valid_in  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid_in = 1'b0;
    key_valid_in  = 1'b0;
  endtask

  // Entered at negedge 1 after acceptance; the pulse must appear at negedge 11.
  task automatic wait_result(input string tag, input logic [127:0] exp_ct);
    int cyc;
    logic [127:0] held;
    cyc = 1;
    while (data_valid_out !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, (data_valid_out === 1'b1) ? 128'(cyc) : 128'd0, 128'd11);
    check({tag, "_ct"}, cipher_text, exp_ct);
    held = cipher_text;
    @(negedge clk);
    check({tag, "_pulse_width"}, 128'(data_valid_out), 128'd0);
    check({tag, "_ct_hold"}, cipher_text, exp_ct);
  endtask

  initial begin
    logic seen;
    reset         = 1'b1;
    data_valid_in = 1'b0;
    key_valid_in  = 1'b0;
    plain_text    = '0;
    cipher_key    = '0;
    repeat (3) @(negedge clk);
    check("reset_dvo", 128'(data_valid_out), 128'd0);
    check("reset_ct", cipher_text, 128'd0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 vectors and the all-zero vector.
    drive_start(P1, K1);
    wait_result("vec1", C1);
    drive_start(P2, K2);
    wait_result("vec2", C2);
    drive_start('0, '0);
    wait_result("zero", C0);

    // Valids held high: a result every 11 cycles, each one cycle wide.
    plain_text    = P1;
    cipher_key    = K1;
    data_valid_in = 1'b1;
    key_valid_in  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      check($sformatf("stream_dvo_c%0d", c), 128'(data_valid_out), 128'((c % 11) == 0));
      if ((c % 11) == 0) check($sformatf("stream_ct_c%0d", c), cipher_text, C1);
    end
    data_valid_in = 1'b0;
    key_valid_in  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while round 5 is in the counter aborts the block.
    drive_start(P2, K2);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_dvo", 128'(data_valid_out), 128'd0);
    check("midreset_ct", cipher_text, 128'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (data_valid_out === 1'b1) seen = 1'b1;
    end
    check("midreset_no_pulse", 128'(seen), 128'd0);
    check("midreset_ct_still0", cipher_text, 128'd0);
    drive_start(P2, K2);
    wait_result("restart", C2);

`ifdef TOP_KEY_REGISTER_EN
    // Key loaded alone, then data alone uses the stored key.
    cipher_key   = K2;
    key_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid_in = 1'b0;
    cipher_key   = '0;
    repeat (3) @(negedge clk);
    plain_text    = P2;
    data_valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_valid_in = 1'b0;
    wait_result("stored_key", C2);
`else
    // A single valid never starts a block.
    plain_text    = P1;
    cipher_key    = K1;
    data_valid_in = 1'b1;
    repeat (3) @(negedge clk);
    data_valid_in = 1'b0;
    key_valid_in  = 1'b1;
    repeat (3) @(negedge clk);
    key_valid_in  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (data_valid_out === 1'b1) seen = 1'b1;
    end
    check("single_valid_no_pulse", 128'(seen), 128'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
# top

AES-128 encryption core: accepts a 128-bit plaintext block and a 128-bit cipher key and produces the FIPS-197 ciphertext. It is iterative, executing one AES round per clock with on-the-fly round-key expansion. It is the top-level cipher datapath; surrounding logic supplies key/data with valid strobes and consumes `cipher_text` on `data_valid_out`.

## Interface
- `KEY_LEN`, default 128: key width. Only 128 is supported.
- `DATA_LEN`, default 128: block width. Only 128 is supported.
- `NUMS_OF_ROUND`, default 10: number of AES rounds. Must be 10.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `data_valid_in` input, 1 bit: `plain_text` is valid.
- `plain_text` input, `DATA_LEN` bits: plaintext block; byte 0 is bits [127:120].
- `key_valid_in` input, 1 bit: `cipher_key` is valid.
- `cipher_key` input, `KEY_LEN` bits: key; byte 0 is bits [127:120].
- `data_valid_out` output, 1 bit: one-cycle pulse marking a valid `cipher_text`.
- `cipher_text` output, `DATA_LEN` bits: ciphertext; holds its value until the next result.

## Operation
- FSM states:
  - IDLE: waiting for a start.
  - RUN: round counter 1..10.
  - DONE: one cycle.
- Start condition: in IDLE or DONE with `data_valid_in` && `key_valid_in`.
  - State register ← `plain_text` ^ `cipher_key`.
  - Key register ← `cipher_key`.
  - Round counter ← 1. Go to RUN.
- RUN, round r = 1..9: state ← MixColumns(ShiftRows(SubBytes(state))) ^ K_r.
- RUN, round 10: MixColumns is omitted.
- K_r is computed combinationally from K_{r-1} in the key register:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r]
  - w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
  - The key register is updated each round.
- After round 10: `cipher_text` ← final state, go to DONE.
- DONE: `data_valid_out` = 1 for exactly this cycle. If the start condition holds, a new block is accepted; otherwise go to IDLE.
- Inputs are ignored in RUN. There is no backpressure.
- MixColumns uses GF(2^8) xtime with reduction polynomial 0x11B.
- The state is column-major: column c = bytes 4c..4c+3.

## Timing
- Start accepted at edge N. Rounds execute at edges N+1..N+10.
- `data_valid_out` is high during the cycle after edge N+10, i.e. 11 cycles after acceptance.
- With both valids held high, one result is produced every 11 cycles.
- Reset while asserted:
  - FSM → IDLE, counter → 0.
  - `data_valid_out` = 0 and `cipher_text` = 0.
  - Reset overrides any simultaneous start.
- Reset mid-operation aborts the block and no output pulse is produced. The first start after reset deasserts behaves as fresh.
- `data_valid_in` without `key_valid_in` (and vice versa) does not start a block.

## Configuration
- `TOP_KEY_REGISTER_EN` defined:
  - In IDLE/DONE, `key_valid_in` alone loads a stored-key register.
  - A start requires only `data_valid_in` and uses the stored key.
  - If both valids are high in the same cycle, the incoming `cipher_key` is used and also stored.
  - The stored key resets to 0.
- Not defined: a start requires both valids in the same cycle. There is no stored-key register.

## Structure
- Package `aes_pkg` holds:
  - the 256-entry S-box constant table;
  - the Rcon constants (01,02,04,08,10,20,40,80,1B,36);
  - the FSM state typedef;
  - functions xtime, sub_word, rot_word, mix_column.
- One sub-module is natural: `aes_key_expand`, the combinational round-key step, with inputs previous key and round index and output the next key.
- Round logic stays in `top`.

## Test plan
- Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, both valids pulsed → `data_valid_out` 11 cycles later with ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32.
- All-zero key and pt → ct 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Valids held high continuously with the first vector → identical result pulses exactly every 11 cycles, each one cycle wide.
- Reset asserted at round 5 → no pulse and `cipher_text` = 0. A restart yields the correct ct 11 cycles after acceptance.
- `data_valid_in` alone (macro off) → no output ever. Macro on: key loaded earlier, then `data_valid_in` alone → correct ct.
